// File: rtl/dly_adj_sequencer.sv
// dly_adj_sequencer: paces load/inc/dec commands into single-cycle delay-decoder pulses and tracks a saturating shadow tap per line
module dly_adj_sequencer #(
    parameter int NUM_DLY = 20,
    parameter int TAP_W   = 6,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [4:0]       cmd_addr,
    input  logic [TAP_W-1:0] cmd_steps,
    output logic             done,
    output logic             err,
    output logic [4:0]       dly_addr,
    output logic             dly_load,
    output logic             dly_adj,
    output logic             dly_incdec,
    input  logic [4:0]       rd_addr,
    output logic [TAP_W-1:0] rd_tap
);
    typedef enum logic [2:0] {IDLE, LOAD, ADJ, WAIT, FIN} state_t;
    state_t state, state_d;
    logic [TAP_W-1:0] shadow [NUM_DLY];
    logic [TAP_W-1:0] rem, nxt_tap;
    logic [3:0] gcnt;
    logic [4:0] nxt_addr;
    logic inc, nxt_inc, accept, legal, lim, fin_err;
    assign accept   = cmd_valid & cmd_ready;
    assign legal    = cmd_addr < 5'(NUM_DLY) && cmd_op != 2'b11;
    assign nxt_addr = accept && legal ? cmd_addr : dly_addr;
    assign nxt_inc  = accept ? cmd_op == 2'b01 : inc;
    // tap as it will stand after this edge, so back-to-back slots see the pulse in flight
    assign nxt_tap  = !dly_adj ? shadow[nxt_addr] :
                      inc ? shadow[nxt_addr] + TAP_W'(1) : shadow[nxt_addr] - TAP_W'(1);
    assign lim      = nxt_inc ? &nxt_tap : nxt_tap == '0;
    assign rd_tap   = rd_addr < 5'(NUM_DLY) ? shadow[rd_addr] : '0;
    always_comb begin
        state_d = state;
        fin_err = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (!legal) begin
                    state_d = FIN;
                    fin_err = 1'b1;
                end else if (cmd_op == 2'b00) state_d = LOAD;
                else state_d = cmd_steps == '0 ? FIN : ADJ;
            end
            LOAD: state_d = FIN;
            ADJ: if (!dly_adj) begin
                state_d = FIN;
                fin_err = 1'b1;
            end else state_d = rem == TAP_W'(1) ? FIN : GAP == 0 ? ADJ : WAIT;
            WAIT: state_d = gcnt == 4'd0 ? ADJ : WAIT;
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            dly_addr   <= '0;
            dly_load   <= 1'b0;
            dly_adj    <= 1'b0;
            dly_incdec <= 1'b0;
            inc        <= 1'b0;
            rem        <= '0;
            gcnt       <= '0;
            for (int i = 0; i < NUM_DLY; i++) shadow[i] <= '0;
        end else begin
            state      <= state_d;
            cmd_ready  <= state_d == IDLE;
            done       <= state_d == FIN;
            err        <= fin_err;
            dly_addr   <= nxt_addr;
            dly_load   <= state_d == LOAD;
            dly_adj    <= state_d == ADJ && !lim;
            dly_incdec <= state_d != IDLE && nxt_inc;
            inc        <= nxt_inc;
            rem        <= accept ? cmd_steps : dly_adj ? rem - TAP_W'(1) : rem;
            gcnt       <= state == WAIT ? gcnt - 4'd1 : 4'(GAP - 1);
            if (dly_adj) shadow[dly_addr] <= nxt_tap;
            if (dly_load) shadow[dly_addr] <= '0;
        end
    end
endmodule

// File: tb/tb_dly_adj_sequencer.sv
// tb_dly_adj_sequencer: directed checks of pulse spacing, saturation, illegal commands and mid-command reset
`timescale 1ns/1ps
module tb_dly_adj_sequencer;
    logic clk, rst_n;
    logic       cmd_valid [2], cmd_ready [2], done [2], err [2];
    logic       dly_load [2], dly_adj [2], dly_incdec [2];
    logic [1:0] cmd_op [2];
    logic [4:0] cmd_addr [2], dly_addr [2], rd_addr [2];
    logic [5:0] cmd_steps [2], rd_tap [2];
    int n_chk = 0, n_pass = 0;

    dly_adj_sequencer #(.NUM_DLY(20), .TAP_W(6), .GAP(2)) u_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_addr(cmd_addr[0]), .cmd_steps(cmd_steps[0]),
        .done(done[0]), .err(err[0]), .dly_addr(dly_addr[0]), .dly_load(dly_load[0]),
        .dly_adj(dly_adj[0]), .dly_incdec(dly_incdec[0]), .rd_addr(rd_addr[0]), .rd_tap(rd_tap[0]));
    dly_adj_sequencer #(.NUM_DLY(20), .TAP_W(6), .GAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_addr(cmd_addr[1]), .cmd_steps(cmd_steps[1]),
        .done(done[1]), .err(err[1]), .dly_addr(dly_addr[1]), .dly_load(dly_load[1]),
        .dly_adj(dly_adj[1]), .dly_incdec(dly_incdec[1]), .rd_addr(rd_addr[1]), .rd_tap(rd_tap[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic rd(input int d, input logic [4:0] a, input int exp, input string tag);
        rd_addr[d] = a;
        #1;
        check(tag, rd_tap[d], exp);
    endtask

    // issue one command on instance d; returns pulse count, misplaced-activity count, load count,
    // cycle of DONE relative to the accepting edge (-1 on timeout) and ERR at DONE
    task automatic run_cmd(input int d, input logic [1:0] op, input logic [4:0] addr, input logic [5:0] steps,
                           output int np, output int bad, output int nl, output int dr, output int er);
        int gp;
        gp = (d == 1) ? 0 : 2;
        np = 0; bad = 0; nl = 0; dr = -1; er = 0;
        for (int t = 0; t < 50 && !cmd_ready[d]; t++) @(negedge clk);
        cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_addr[d] = addr; cmd_steps[d] = steps;
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        for (int r = 1; r < 400 && dr < 0; r++) begin
            if (dly_adj[d]) begin
                if (r != 1 + np * (gp + 1) || dly_addr[d] != addr || dly_incdec[d] != (op == 2'b01)) bad++;
                np++;
            end
            if (dly_load[d]) begin
                if (r != 1 || dly_addr[d] != addr) bad++;
                nl++;
            end
            if (cmd_ready[d]) bad++;
            if (done[d]) begin
                dr = r;
                er = err[d];
            end else @(negedge clk);
        end
    endtask

    initial begin
        int np, bad, nl, dr, er, cnt;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 0; cmd_op[d] = 0; cmd_addr[d] = 0; cmd_steps[d] = 0; rd_addr[d] = 0;
        end
        #22;
        check("rst_outs", {cmd_ready[0], done[0], err[0], dly_addr[0], dly_load[0], dly_adj[0], dly_incdec[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_at_release", cmd_ready[0], 0);
        @(negedge clk);
        check("ready_after_edge", cmd_ready[0], 1);

        run_cmd(0, 2'b01, 5'd3, 6'd4, np, bad, nl, dr, er);
        check("inc3_pulses", np, 4);
        check("inc3_ctl", bad, 0);
        check("inc3_done", dr, 11);
        check("inc3_err", er, 0);
        rd(0, 5'd3, 4, "inc3_tap");

        run_cmd(0, 2'b00, 5'd3, 6'd9, np, bad, nl, dr, er);
        check("load3_loads", nl, 1);
        check("load3_ctl", bad + np, 0);
        check("load3_done", dr, 2);
        check("load3_err", er, 0);
        rd(0, 5'd3, 0, "load3_tap");

        run_cmd(0, 2'b01, 5'd19, 6'd63, np, bad, nl, dr, er);
        check("inc19_pulses", np, 63);
        check("inc19_ctl", bad, 0);
        check("inc19_done", dr, 188);
        rd(0, 5'd19, 63, "inc19_tap");
        run_cmd(0, 2'b01, 5'd19, 6'd5, np, bad, nl, dr, er);
        check("sat19_pulses", np, 0);
        check("sat19_done", dr, 2);
        check("sat19_err", er, 1);
        rd(0, 5'd19, 63, "sat19_tap");

        run_cmd(0, 2'b10, 5'd0, 6'd1, np, bad, nl, dr, er);
        check("dec0_pulses", np, 0);
        check("dec0_done", dr, 2);
        check("dec0_err", er, 1);
        rd(0, 5'd0, 0, "dec0_tap");

        run_cmd(1, 2'b01, 5'd7, 6'd62, np, bad, nl, dr, er);
        check("g0_inc7_pulses", np, 62);
        check("g0_inc7_ctl", bad, 0);
        check("g0_inc7_done", dr, 63);
        rd(1, 5'd7, 62, "g0_inc7_tap");
        run_cmd(1, 2'b01, 5'd7, 6'd3, np, bad, nl, dr, er);
        check("g0_sat7_pulses", np, 1);
        check("g0_sat7_ctl", bad, 0);
        check("g0_sat7_done", dr, 3);
        check("g0_sat7_err", er, 1);
        rd(1, 5'd7, 63, "g0_sat7_tap");

        run_cmd(0, 2'b01, 5'd20, 6'd3, np, bad, nl, dr, er);
        check("bad_addr_act", np + nl + bad, 0);
        check("bad_addr_done", dr, 1);
        check("bad_addr_err", er, 1);
        run_cmd(0, 2'b11, 5'd2, 6'd3, np, bad, nl, dr, er);
        check("bad_op_act", np + nl + bad, 0);
        check("bad_op_done", dr, 1);
        check("bad_op_err", er, 1);
        run_cmd(0, 2'b01, 5'd5, 6'd0, np, bad, nl, dr, er);
        check("zero_act", np + nl + bad, 0);
        check("zero_done", dr, 1);
        check("zero_err", er, 0);
        rd(0, 5'd20, 0, "rd_oob");

        // reset in the gap after the second of five pulses, with cmd_valid held high throughout
        for (int t = 0; t < 50 && !cmd_ready[0]; t++) @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_op[0] = 2'b01; cmd_addr[0] = 5'd4; cmd_steps[0] = 6'd5;
        np = 0;
        for (int r = 0; r < 30 && np < 2; r++) begin
            @(negedge clk);
            if (dly_adj[0]) np++;
        end
        check("pre_rst_pulses", np, 2);
        @(negedge clk);
        check("pre_rst_incdec", dly_incdec[0], 1);
        cmd_steps[0] = 6'd1;
        #2 rst_n = 1'b0;
        #1 check("mid_rst_outs", {cmd_ready[0], done[0], err[0], dly_addr[0], dly_load[0], dly_adj[0], dly_incdec[0]}, 0);
        rd(0, 5'd4, 0, "mid_rst_tap4");
        rd(0, 5'd19, 0, "mid_rst_tap19");
        rd(1, 5'd7, 0, "mid_rst_b_tap7");
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0] || cmd_ready[0]) cnt++;
        end
        check("rst_hold_quiet", cnt, 0);
        rst_n = 1'b1;
        #1 check("rel_ready0", cmd_ready[0], 0);
        @(negedge clk);
        check("rel_ready1", cmd_ready[0], 1);
        check("rel_no_adj", dly_adj[0] | done[0], 0);
        @(negedge clk);
        check("acc_ready", cmd_ready[0], 0);
        check("acc_adj", dly_adj[0], 1);
        check("acc_addr", dly_addr[0], 4);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        check("acc_done", done[0], 1);
        check("acc_err", err[0], 0);
        rd(0, 5'd4, 1, "acc_tap4");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dly_adj_sequencer.md
# dly_adj_sequencer

Command-driven sequencer for the 20 I/O delay lines behind the delay select decoder. It accepts one command at a time (load, increment by N, decrement by N) and drives the decoder inputs `DLY_ADDR`, `DLY_LOAD`, `DLY_ADJ` and `DLY_INCDEC` as correctly spaced single-cycle pulses. It also keeps a shadow tap count per delay line, saturates at the tap range limits, and flags illegal requests. It sits between fabric control logic (training FSMs, a CSR bridge) and the decoder.

## Interface
- `NUM_DLY`, 20: number of delay lines; legal addresses are 0..NUM_DLY-1.
- `TAP_W`, 6: shadow tap width; tap range is 0..2^TAP_W-1.
- `GAP`, 2: idle cycles inserted between consecutive `DLY_ADJ` pulses; legal range 0..15.
- `CLK`  in  1  the block's single clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous reset, active-low.
- `CMD_VALID`  in  1  command request.
- `CMD_READY`  out  1  the sequencer can accept a command.
- `CMD_OP`  in  2  00 = load, 01 = increment, 10 = decrement, 11 = reserved (treated as an error).
- `CMD_ADDR`  in  5  target delay line.
- `CMD_STEPS`  in  TAP_W  number of adjust steps; ignored for load.
- `DONE`  out  1  one-cycle pulse at command completion.
- `ERR`  out  1  one-cycle pulse coincident with `DONE` when the command failed or was truncated.
- `DLY_ADDR`  out  5  address to the decoder.
- `DLY_LOAD`, `DLY_ADJ`, `DLY_INCDEC`  out  1 each  control outputs to the decoder.
- `RD_ADDR`  in  5  shadow readback address.
- `RD_TAP`  out  TAP_W  shadow tap of `RD_ADDR`. Combinational. Returns 0 if `RD_ADDR` ≥ NUM_DLY.

## Operation
- FSM states:
  - IDLE: `CMD_READY`=1.
  - LOAD: one cycle.
  - ADJ: one pulse cycle.
  - WAIT: GAP cycles.
  - FIN: one cycle, then IDLE.
- A command is accepted when `CMD_VALID` & `CMD_READY`. The sequencer latches `CMD_OP`, `CMD_ADDR` and `CMD_STEPS`.
- Illegal command (`CMD_ADDR` ≥ NUM_DLY, or `CMD_OP`=11):
  - Goes directly to FIN.
  - No pulses are issued. `ERR`=1 with `DONE`.
- Load:
  - `DLY_LOAD`=1 for one cycle with `DLY_ADDR`=addr.
  - The addressed shadow tap is set to 0.
- Increment / decrement:
  - `DLY_INCDEC` = 1 for increment, 0 for decrement. It is held, together with `DLY_ADDR`, from acceptance until FIN.
  - Up to `CMD_STEPS` `DLY_ADJ` pulses are issued, each exactly one cycle, separated by GAP cycles with `DLY_ADJ`=0.
  - Each pulse changes the shadow tap by ±1 at the end of the pulse cycle.
- `CMD_STEPS`=0: the command goes directly to FIN with no pulse; `ERR`=0.
- Saturation:
  - Before each pulse slot, the shadow tap is checked: 2^TAP_W-1 for increment, 0 for decrement.
  - If it is at the limit, the pulse is suppressed, the remaining steps are dropped, and the FSM goes to FIN with `ERR`=1.
  - The shadow tap never wraps.
- Outside LOAD/ADJ, `DLY_LOAD`=0 and `DLY_ADJ`=0.
- In IDLE, `DLY_INCDEC`=0 and `DLY_ADDR` holds the last address.
- `CMD_*` inputs are ignored while `CMD_READY`=0.

## Timing
- Reset values of all outputs and state:
  - `CMD_READY`=0, `DONE`=0, `ERR`=0.
  - `DLY_ADDR`=0, `DLY_LOAD`=0, `DLY_ADJ`=0, `DLY_INCDEC`=0.
  - All shadow taps = 0; FSM in IDLE.
- `CMD_READY` is registered and rises on the first `CLK` edge after `RST` deasserts.
- All control outputs are registered; there is no combinational path from `CMD_*` to `DLY_*`.
- Acceptance at edge T gives the following cycle timing:
  - Load: `DLY_LOAD` high in cycle T+1. `DONE` in cycle T+2.
  - Increment/decrement with N steps and no saturation: `DLY_ADJ` pulses in cycles T+1+k(GAP+1) for k=0..N-1. `DONE` in cycle T+2+(N-1)(GAP+1).
  - N=0 or illegal command: `DONE` in cycle T+1.
  - Saturation at slot k: no pulse in that slot; `DONE`+`ERR` in the following cycle.
- `CMD_READY`=0 from T+1 through the FIN cycle. It is 1 in the cycle after `DONE`, so the earliest next acceptance is one cycle after `DONE`.
- `RD_TAP` reflects a shadow update in the cycle after the pulse.
- Reset asserted mid-command:
  - All outputs and shadows clear immediately (asynchronously).
  - The command is dropped; no `DONE` is issued.

## Test plan
- Reset release, then increment addr 3 by 4 steps with GAP=2, accepted at T:
  - `DLY_ADJ` pulses at T+1, T+4, T+7, T+10 with `DLY_INCDEC`=1 and `DLY_ADDR`=3.
  - `DONE` at T+11, `ERR`=0, `RD_TAP`(3)=4.
- Load addr 3 after that sequence: `DLY_LOAD` high in one cycle only, `DONE` one cycle later, `RD_TAP`(3)=0.
- Saturation:
  - Increment addr 19 by 63, then by 5: the second command issues zero pulses, and `DONE`+`ERR` fire one cycle after the first slot; tap stays 63.
  - Decrement addr 0 from 0 by 1: same behaviour, tap stays 0.
- Increment addr 7 by 3 from tap 62 with GAP=0: exactly one pulse, then `ERR` with `DONE`; tap=63.
- Illegal commands:
  - `CMD_ADDR`=20 or `CMD_OP`=11: `DONE`+`ERR` at T+1, no `DLY_LOAD`/`DLY_ADJ` activity.
  - `CMD_STEPS`=0: `DONE` at T+1, `ERR`=0.
- Assert `RST` between the second and third pulses of a 5-step increment:
  - All outputs go to 0 immediately, no `DONE`, all shadows 0.
  - `CMD_READY` rises on the first edge after release.
  - `CMD_VALID` held high throughout is accepted only when `CMD_READY`=1.
